// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum stream reader.
package spectrum_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int BIN_W    = 5;
  localparam int SPEC_LEN = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_READ,
    S_DRAIN,
    S_GAP
  } state_e;

  // RAM address layout: range bin in the upper bits, sample index below.
  function automatic logic [BIN_W+ADDR_W-1:0] pack_addr(input logic [BIN_W-1:0]  bin,
                                                         input logic [ADDR_W-1:0] smp);
    return {bin, smp};
  endfunction

endpackage

// File: rtl/ssr_align_pipe.sv
// Delay line that carries valid, sample index and bin index alongside the
// RAM read data path, so they emerge aligned with the registered sample.
module ssr_align_pipe #(
  parameter int ADDR_W = 10,
  parameter int BIN_W  = 5,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              mid_vld_o,
  output logic [ADDR_W-1:0] mid_addr_o,
  output logic [BIN_W-1:0]  mid_bin_o,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BIN_W-1:0]  bin_o
);

  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][ADDR_W-1:0] addr_pipe;
  logic [STAGES:1][BIN_W-1:0]  bin_pipe;

  // Shift register; stage 1 lines up with RAM data, last stage with D_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      bin_pipe  <= '0;
    end else begin
      vld_pipe[1]  <= vld_i;
      addr_pipe[1] <= addr_i;
      bin_pipe[1]  <= bin_i;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
        bin_pipe[s]  <= bin_pipe[s-1];
      end
    end
  end

  assign mid_vld_o  = vld_pipe[1];
  assign mid_addr_o = addr_pipe[1];
  assign mid_bin_o  = bin_pipe[1];
  assign vld_o      = vld_pipe[STAGES];
  assign addr_o     = addr_pipe[STAGES];
  assign bin_o      = bin_pipe[STAGES];

endmodule

// File: rtl/spectrum_stream_reader.sv
// Streams accumulated spectra out of the range-bin RAM one bin at a time,
// with an idle gap between bursts so the peak detector clears per bin.
// Optional feature: define SSR_TEST_PATTERN_EN to let test_mode replace the
// RAM data with {bin, sample}.
module spectrum_stream_reader #(
  parameter int ADDR_W  = spectrum_pkg::ADDR_W,
  parameter int DATA_W  = spectrum_pkg::DATA_W,
  parameter int BIN_W   = spectrum_pkg::BIN_W,
  parameter int GAP_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        RangBin_total,
  input  logic                    ds_ready,
  input  logic                    test_mode,
  output logic                    ram_rd_en,
  output logic [BIN_W+ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0]       ram_rd_data,
  output logic                    data_valid_out,
  output logic [DATA_W-1:0]       D_out,
  output logic [ADDR_W-1:0]       D_addr,
  output logic [BIN_W-1:0]        RangBin_counts,
  output logic                    busy,
  output logic                    frame_done
);
  import spectrum_pkg::*;

  localparam int TMR_W = $clog2(GAP_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_SMP = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  smp_q, smp_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BIN_W-1:0]   total_q, total_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               done_q, done_d;
  logic               last_bin;

  logic               s1_vld;
  logic [ADDR_W-1:0]  s1_addr;
  logic [BIN_W-1:0]   s1_bin;
  logic [DATA_W-1:0]  smp_data;
  logic [DATA_W-1:0]  dout_q;

  // Only the latched total matters once a frame is running.
  assign last_bin = (bin_q == total_q - BIN_W'(1));

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      smp_q   <= '0;
      bin_q   <= '0;
      total_q <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bin_q   <= bin_d;
      total_q <= total_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; a burst, once started, always runs to its end.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bin_d   = bin_q;
    total_d = total_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (RangBin_total != '0) begin
            total_d = RangBin_total;
            bin_d   = '0;
            smp_d   = '0;
            state_d = S_WAIT_RDY;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT_RDY: begin
        if (ds_ready) state_d = S_READ;
      end
      S_READ: begin
        smp_d = smp_q + ADDR_W'(1);
        if (smp_q == LAST_SMP) begin
          tmr_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(1)) begin
          tmr_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
          tmr_d = '0;
          if (last_bin) begin
            bin_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bin_d   = bin_q + BIN_W'(1);
            state_d = S_WAIT_RDY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_rd_en   = (state_q == S_READ);
  assign ram_rd_addr = pack_addr(bin_q, smp_q);
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;

  ssr_align_pipe #(
    .ADDR_W (ADDR_W),
    .BIN_W  (BIN_W),
    .STAGES (2)
  ) u_align (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld_i      (ram_rd_en),
    .addr_i     (smp_q),
    .bin_i      (bin_q),
    .mid_vld_o  (s1_vld),
    .mid_addr_o (s1_addr),
    .mid_bin_o  (s1_bin),
    .vld_o      (data_valid_out),
    .addr_o     (D_addr),
    .bin_o      (RangBin_counts)
  );

`ifdef SSR_TEST_PATTERN_EN
  // Bring-up pattern uses the stage-1 tags, which match the RAM data slot.
  assign smp_data = test_mode ? DATA_W'(pack_addr(s1_bin, s1_addr)) : ram_rd_data;
`else
  logic unused_tags;
  assign unused_tags = ^{test_mode, s1_addr, s1_bin};
  assign smp_data    = ram_rd_data;
`endif

  // Output data register; holds the last sample outside a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout_q <= '0;
    else if (s1_vld) dout_q <= smp_data;
  end

  assign D_out = dout_q;

endmodule

// File: doc/spectrum_stream_reader.md
# spectrum_stream_reader

Reads accumulated 1024-point power spectra out of the range-bin accumulation RAM and streams them, one range bin at a time, to the peak detector as a contiguous `data_valid` / `D_addr` / `D_out` burst. It is the producing end of the peak-detection input stream and sits between the accumulator RAM read port and the peak detector. Each bin burst is separated by a guaranteed idle gap, so the downstream per-bin counter and peak registers clear between bins.

## Interface
Parameters:
- `ADDR_W`, 10: spectrum sample address width (`SPEC_LEN = 2**ADDR_W`).
- `DATA_W`, 32: spectrum sample width.
- `BIN_W`, 5: range-bin index width.
- `GAP_CYC`, 8: minimum idle cycles between bin bursts (≥2).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a frame readout.
- `RangBin_total`  in  BIN_W  number of bins to stream; latched on an accepted `start`.
- `ds_ready`  in  1  level signal; the downstream can accept a new bin burst.
- `test_mode`  in  1  selects the test pattern (see Configuration).
- `ram_rd_en`  out  1  RAM read enable.
- `ram_rd_addr`  out  BIN_W+ADDR_W  RAM address `{bin, sample}`.
- `ram_rd_data`  in  DATA_W  RAM data, valid one cycle after `ram_rd_en`.
- `data_valid_out`  out  1  a stream sample is valid.
- `D_out`  out  DATA_W  stream sample.
- `D_addr`  out  ADDR_W  sample index aligned with `D_out`.
- `RangBin_counts`  out  BIN_W  bin index aligned with `D_out`.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last sample of the frame.

## Operation
- FSM states: IDLE, WAIT_RDY, READ, DRAIN, GAP.
- **IDLE**
  - `start` with `RangBin_total != 0`: latch the total, clear the bin index, go to WAIT_RDY, set `busy`.
  - `start` with `RangBin_total == 0`: pulse `frame_done` on the next cycle and stay in IDLE.
- **WAIT_RDY**: move to READ on the first cycle in which `ds_ready` = 1.
- **READ**
  - Assert `ram_rd_en` every cycle; the sample counter runs 0..SPEC_LEN-1.
  - When the counter reaches SPEC_LEN-1, go to DRAIN.
  - `ds_ready` is ignored during a burst; a burst is never broken.
- **DRAIN**: 2 cycles while the pipeline empties.
- **GAP**: hold for GAP_CYC cycles, then:
  - advance the bin index;
  - if the last bin is done, go to IDLE, pulse `frame_done` and clear `busy`;
  - otherwise go to WAIT_RDY.
- `start` is ignored while `busy` is high.
- Address and width rules:
  - The sample counter wraps naturally at ADDR_W bits.
  - The bin index is compared against `RangBin_total - 1`.
  - Only the latched `RangBin_total` is used; changes to the input mid-frame have no effect.
- Reset (including mid-burst) asynchronously returns the FSM to IDLE. All outputs reset to 0; `frame_done` is not pulsed.

## Timing
- `start` sampled at edge 0: READ begins at cycle 1 with `ram_rd_addr` = `{0,0}`.
- RAM data arrives at cycle 2 and is registered into `D_out` at cycle 3.
- Latency from address to output is 2 cycles. `D_addr`, `RangBin_counts` and `data_valid_out` pass through the same 2-stage delay as the data.
- `data_valid_out` is high for exactly SPEC_LEN consecutive cycles per bin.
- Between bursts, `data_valid_out` is low for at least GAP_CYC cycles (more if `ds_ready` is low).
- `frame_done` asserts the cycle after the final GAP cycle.

## Configuration
- `SSR_TEST_PATTERN_EN` defined: while `test_mode` = 1, `D_out` = `{bin, sample}` zero-extended to DATA_W.
  - RAM reads and all timing are unchanged; only the data is replaced.
  - Intended for bring-up of the peak-detection path.
- `SSR_TEST_PATTERN_EN` undefined: `test_mode` is ignored and `D_out` always carries RAM data.

## Structure
- Shared package `spectrum_pkg` holds:
  - `ADDR_W`, `DATA_W`, `BIN_W`, `SPEC_LEN`;
  - the FSM state enum;
  - the `{bin, sample}` address-packing function.
- One sub-module, `ssr_align_pipe`, is the 2-stage delay line for valid, sample index and bin index, so that they stay aligned with the RAM data path.

## Test plan
- `RangBin_total` = 3, `ds_ready` = 1, RAM preloaded with `{bin,addr}`:
  - 3 bursts of 1024 valid samples;
  - `D_out` equals `{bin,D_addr}` on every sample;
  - gaps of ≥8 cycles between bursts;
  - `frame_done` pulses once.
- `start` at cycle 0: the first `data_valid_out` is at cycle 3 with `D_addr` = 0; the last sample of bin 0 is at cycle 1026.
- `ds_ready` low for 50 cycles after bin 0: the bin 1 burst starts only after `ds_ready` rises; bin 0 is unaffected.
- `RangBin_total` = 0: `frame_done` one cycle after `start`; `ram_rd_en` never asserts.
- `rst_n` pulsed at sample 400 of bin 1: outputs are 0 immediately, `busy` is 0, and no `frame_done`. A new `start` restarts from bin 0.
- `start` re-pulsed mid-frame, and `RangBin_total` changed mid-frame: no effect on the frame.
- With `SSR_TEST_PATTERN_EN` defined and `test_mode` = 1: the pattern appears even with an all-zero RAM.
